// File: rtl/zl_dvb_s_puncturer.sv
// zl_dvb_s_puncturer
// Punctures the rate-1/2 mother code of a DVB-S convolutional encoder down to
// 2/3, 3/4, 5/6 or 7/8. The kept bits form one serial stream, which leaves the
// block as (I,Q) pairs through a single output register.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   rate[2:0]           code-rate select (0=1/2 1=2/3 2=3/4 3=5/6 4=7/8, 5-7 -> 1/2)
//   data_in_i/q         mother-code bits X/Y
//   data_in_req/ack     input handshake (transfer when both are high)
//   data_out_i/q        punctured pair
//   data_out_req/ack    output handshake
//   rate_active[2:0]    rate in force for the current puncture period
//
// Parameter
//   Swap_iq             0: first stream bit of a pair goes to I; 1: goes to Q

module zl_dvb_s_puncturer #(
    parameter int Swap_iq = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] rate,
    input  logic       data_in_i,
    input  logic       data_in_q,
    input  logic       data_in_req,
    output logic       data_in_ack,
    output logic       data_out_i,
    output logic       data_out_q,
    output logic       data_out_req,
    input  logic       data_out_ack,
    output logic [2:0] rate_active
);

    logic [2:0] phase;
    logic       left_valid;
    logic       left_bit;

    logic [2:0] rate_norm;
    logic [2:0] rate_eff;
    logic [2:0] period;
    logic [6:0] x_pat;
    logic [6:0] y_pat;
    logic       keep_x;
    logic       keep_y;
    logic       in_xfer;
    logic       out_xfer;
    logic       has_pair;
    logic       pair_a;
    logic       pair_b;
    logic       left_valid_nxt;
    logic       left_bit_nxt;

    assign data_in_ack = !rst && (!data_out_req || data_out_ack);
    assign in_xfer     = data_in_req && data_in_ack;
    assign out_xfer    = data_out_req && data_out_ack;

    assign rate_norm = (rate > 3'd4) ? 3'd0 : rate;
    // At a period start the incoming rate governs this very input; mid-period
    // the latched rate is used so a rate change never splits a period.
    assign rate_eff  = (phase == 3'd0) ? rate_norm : rate_active;

    // Pattern bit k sits at vector index k (position 0 is the LSB).
    always_comb begin
        period = 3'd1;
        x_pat  = 7'b0000001;
        y_pat  = 7'b0000001;
        case (rate_eff)
            3'd1: begin period = 3'd2; x_pat = 7'b0000001; y_pat = 7'b0000011; end
            3'd2: begin period = 3'd3; x_pat = 7'b0000101; y_pat = 7'b0000011; end
            3'd3: begin period = 3'd5; x_pat = 7'b0010101; y_pat = 7'b0001011; end
            3'd4: begin period = 3'd7; x_pat = 7'b1010001; y_pat = 7'b0101111; end
            default: ;
        endcase
    end

    assign keep_x = x_pat[phase];
    assign keep_y = y_pat[phase];

    // Merge the kept bits of this input behind the leftover bit (if any).
    always_comb begin
        has_pair       = 1'b0;
        pair_a         = 1'b0;
        pair_b         = 1'b0;
        left_valid_nxt = left_valid;
        left_bit_nxt   = left_bit;
        if (keep_x && keep_y) begin
            has_pair = 1'b1;
            if (left_valid) begin
                pair_a       = left_bit;
                pair_b       = data_in_i;
                left_bit_nxt = data_in_q;
            end else begin
                pair_a         = data_in_i;
                pair_b         = data_in_q;
                left_valid_nxt = 1'b0;
            end
        end else if (keep_x || keep_y) begin
            if (left_valid) begin
                has_pair       = 1'b1;
                pair_a         = left_bit;
                pair_b         = keep_x ? data_in_i : data_in_q;
                left_valid_nxt = 1'b0;
            end else begin
                left_valid_nxt = 1'b1;
                left_bit_nxt   = keep_x ? data_in_i : data_in_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase        <= 3'd0;
            left_valid   <= 1'b0;
            left_bit     <= 1'b0;
            rate_active  <= 3'd0;
            data_out_req <= 1'b0;
            data_out_i   <= 1'b0;
            data_out_q   <= 1'b0;
        end else begin
            if (in_xfer) begin
                phase      <= (phase == period - 3'd1) ? 3'd0 : phase + 3'd1;
                left_valid <= left_valid_nxt;
                left_bit   <= left_bit_nxt;
                if (phase == 3'd0)
                    rate_active <= rate_norm;
            end
            // A load can only coincide with a full register when it is being
            // unloaded (data_in_ack guarantees that), so load wins over clear.
            if (in_xfer && has_pair) begin
                data_out_i   <= (Swap_iq != 0) ? pair_b : pair_a;
                data_out_q   <= (Swap_iq != 0) ? pair_a : pair_b;
                data_out_req <= 1'b1;
            end else if (out_xfer) begin
                data_out_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zl_dvb_s_puncturer.sv
module tb_zl_dvb_s_puncturer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rate = 3'd0;
    logic       data_in_i = 1'b0;
    logic       data_in_q = 1'b0;
    logic       data_in_req = 1'b0;
    logic       data_in_ack;
    logic       data_out_i;
    logic       data_out_q;
    logic       data_out_req;
    logic       data_out_ack = 1'b0;
    logic [2:0] rate_active;

    logic       sw_in_ack, sw_out_i, sw_out_q, sw_out_req;
    logic [2:0] sw_rate_active;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    zl_dvb_s_puncturer #(.Swap_iq(0)) dut (
        .clk(clk), .rst(rst), .rate(rate),
        .data_in_i(data_in_i), .data_in_q(data_in_q),
        .data_in_req(data_in_req), .data_in_ack(data_in_ack),
        .data_out_i(data_out_i), .data_out_q(data_out_q),
        .data_out_req(data_out_req), .data_out_ack(data_out_ack),
        .rate_active(rate_active)
    );

    zl_dvb_s_puncturer #(.Swap_iq(1)) dut_sw (
        .clk(clk), .rst(rst), .rate(rate),
        .data_in_i(data_in_i), .data_in_q(data_in_q),
        .data_in_req(data_in_req), .data_in_ack(sw_in_ack),
        .data_out_i(sw_out_i), .data_out_q(sw_out_q),
        .data_out_req(sw_out_req), .data_out_ack(data_out_ack),
        .rate_active(sw_rate_active)
    );

    task automatic check(input bit ok, input string name, input int act, input int exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: pattern strings, bit queue ----------
    string xs [5] = '{"1", "10", "101", "10101", "1000101"};
    string ys [5] = '{"1", "11", "110", "11010", "1111010"};
    bit          bits[$];
    logic [1:0]  expq[$];
    int          m_phase = 0;
    int          m_rate = 0;
    bit          mon_en = 1'b0;

    task automatic model_reset();
        bits.delete();
        expq.delete();
        m_phase = 0;
        m_rate  = 0;
    endtask

    task automatic model_accept(input int r, input bit x, input bit y);
        string sx, sy;
        if (m_phase == 0) m_rate = (r > 4) ? 0 : r;
        sx = xs[m_rate];
        sy = ys[m_rate];
        if (sx[m_phase] == 8'h31) bits.push_back(x);
        if (sy[m_phase] == 8'h31) bits.push_back(y);
        while (bits.size() >= 2) begin
            expq.push_back({bits[0], bits[1]});
            void'(bits.pop_front());
            void'(bits.pop_front());
        end
        m_phase = (m_phase + 1) % sx.len();
    endtask

    logic [1:0] prev_data;
    bit         prev_stall = 1'b0;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check(data_in_ack == (!data_out_req || data_out_ack), "in_ack_rule",
                  int'(data_in_ack), int'(!data_out_req || data_out_ack));
            check(int'(rate_active) == m_rate, "rate_active_model", int'(rate_active), m_rate);
            if (data_out_req)
                check({sw_out_i, sw_out_q} == {data_out_q, data_out_i}, "swap_iq",
                      int'({sw_out_i, sw_out_q}), int'({data_out_q, data_out_i}));
            if (prev_stall && data_out_req)
                check({data_out_i, data_out_q} == prev_data, "hold_stable",
                      int'({data_out_i, data_out_q}), int'(prev_data));
            if (prev_stall)
                check(data_out_req == 1'b1, "hold_req", int'(data_out_req), 1);
            if (data_out_req && data_out_ack) begin
                if (expq.size() == 0) begin
                    check(1'b0, "spurious_out", int'({data_out_i, data_out_q}), -1);
                end else begin
                    logic [1:0] e;
                    e = expq.pop_front();
                    check({data_out_i, data_out_q} == e, "out_pair",
                          int'({data_out_i, data_out_q}), int'(e));
                end
            end
            prev_stall = data_out_req && !data_out_ack;
            prev_data  = {data_out_i, data_out_q};
            if (data_in_req && data_in_ack)
                model_accept(int'(rate), data_in_i, data_in_q);
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- directed table ----------------------------------------
    typedef struct {
        logic [2:0] rate;
        logic       x, y, req, oack;
        logic       e_req, e_i, e_q;
        logic [2:0] e_ra;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [2:0] r, input logic x, input logic y,
                                input logic req, input logic oack, input logic e_req,
                                input logic e_i, input logic e_q, input logic [2:0] e_ra);
        vec_t v;
        v.rate = r; v.x = x; v.y = y; v.req = req; v.oack = oack;
        v.e_req = e_req; v.e_i = e_i; v.e_q = e_q; v.e_ra = e_ra;
        return v;
    endfunction

    task automatic drive(input logic [2:0] r, input logic x, input logic y,
                         input logic req, input logic oack);
        rate = r; data_in_i = x; data_in_q = y; data_in_req = req; data_out_ack = oack;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    logic [1:0] held;

    initial begin
        // rate 1/2: two pairs straight through, one cycle latency
        tbl.push_back(mk(3'd0, 1, 0, 1, 1, 1, 1, 0, 3'd0));
        tbl.push_back(mk(3'd0, 0, 1, 1, 1, 1, 0, 1, 3'd0));
        tbl.push_back(mk(3'd0, 0, 0, 0, 1, 0, 0, 0, 3'd0));
        // rate 3/4
        tbl.push_back(mk(3'd2, 1, 0, 1, 1, 1, 1, 0, 3'd2));
        tbl.push_back(mk(3'd2, 0, 1, 1, 1, 0, 0, 0, 3'd2));
        tbl.push_back(mk(3'd2, 1, 1, 1, 1, 1, 1, 1, 3'd2));
        tbl.push_back(mk(3'd2, 0, 0, 0, 1, 0, 0, 0, 3'd2));
        // rate 7/8, seven (1,0)
        tbl.push_back(mk(3'd4, 1, 0, 1, 1, 1, 1, 0, 3'd4));
        tbl.push_back(mk(3'd4, 1, 0, 1, 1, 0, 0, 0, 3'd4));
        tbl.push_back(mk(3'd4, 1, 0, 1, 1, 1, 0, 0, 3'd4));
        tbl.push_back(mk(3'd4, 1, 0, 1, 1, 0, 0, 0, 3'd4));
        tbl.push_back(mk(3'd4, 1, 0, 1, 1, 1, 0, 1, 3'd4));
        tbl.push_back(mk(3'd4, 1, 0, 1, 1, 0, 0, 0, 3'd4));
        tbl.push_back(mk(3'd4, 1, 0, 1, 1, 1, 0, 1, 3'd4));
        tbl.push_back(mk(3'd4, 0, 0, 0, 1, 0, 0, 0, 3'd4));
        // rate 3/4 then switch to 1/2 mid-period
        tbl.push_back(mk(3'd2, 1, 1, 1, 1, 1, 1, 1, 3'd2));
        tbl.push_back(mk(3'd0, 1, 0, 1, 1, 0, 0, 0, 3'd2));
        tbl.push_back(mk(3'd0, 0, 1, 1, 1, 1, 0, 0, 3'd2));
        tbl.push_back(mk(3'd0, 1, 0, 1, 1, 1, 1, 0, 3'd0));
        tbl.push_back(mk(3'd0, 0, 0, 0, 1, 0, 0, 0, 3'd0));
        // out-of-range rate behaves as 1/2 and reports 0
        tbl.push_back(mk(3'd6, 0, 1, 1, 1, 1, 0, 1, 3'd0));
        tbl.push_back(mk(3'd6, 0, 0, 0, 1, 0, 0, 0, 3'd0));

        // reset state, with downstream ready so in_ack is forced by rst alone
        data_out_ack = 1'b1;
        #2;
        check(data_out_req == 1'b0, "rst_out_req", int'(data_out_req), 0);
        check({data_out_i, data_out_q} == 2'b00, "rst_out_data", int'({data_out_i, data_out_q}), 0);
        check(data_in_ack == 1'b0, "rst_in_ack", int'(data_in_ack), 0);
        check(rate_active == 3'd0, "rst_rate_active", int'(rate_active), 0);
        do_reset();

        foreach (tbl[n]) begin
            drive(tbl[n].rate, tbl[n].x, tbl[n].y, tbl[n].req, tbl[n].oack);
            cycle();
            check(data_out_req == tbl[n].e_req, $sformatf("tbl%0d_req", n),
                  int'(data_out_req), int'(tbl[n].e_req));
            if (tbl[n].e_req)
                check({data_out_i, data_out_q} == {tbl[n].e_i, tbl[n].e_q},
                      $sformatf("tbl%0d_data", n), int'({data_out_i, data_out_q}),
                      int'({tbl[n].e_i, tbl[n].e_q}));
            check(rate_active == tbl[n].e_ra, $sformatf("tbl%0d_rate_active", n),
                  int'(rate_active), int'(tbl[n].e_ra));
        end

        // backpressure: stall for 5 cycles while streaming at 1/2
        do_reset();
        mon_en = 1'b1;
        for (int n = 0; n < 3; n++) begin
            drive(3'd0, 1'($urandom), 1'($urandom), 1'b1, 1'b1);
            cycle();
        end
        held = {data_out_i, data_out_q};
        drive(3'd0, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) begin
            #1;
            check(data_in_ack == 1'b0, "stall_in_ack", int'(data_in_ack), 0);
            cycle();
            check(data_out_req == 1'b1, "stall_req", int'(data_out_req), 1);
            check({data_out_i, data_out_q} == held, "stall_data",
                  int'({data_out_i, data_out_q}), int'(held));
        end
        for (int n = 0; n < 3; n++) begin
            drive(3'd0, 1'($urandom), 1'($urandom), 1'b1, 1'b1);
            cycle();
        end
        drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 4; n++) cycle();
        check(expq.size() == 0, "stall_drain", expq.size(), 0);
        mon_en = 1'b0;

        // reset with a pending pair after the first 2/3 input
        do_reset();
        drive(3'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle();
        drive(3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        check(data_out_req == 1'b1, "pre_rst_req", int'(data_out_req), 1);
        rst = 1'b1;
        #1;
        check(data_out_req == 1'b0, "async_rst_req", int'(data_out_req), 0);
        check(data_in_ack == 1'b0, "async_rst_in_ack", int'(data_in_ack), 0);
        cycle();
        rst = 1'b0;
        drive(3'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle();
        check(data_out_req == 1'b1, "post_rst_phase0_req", int'(data_out_req), 1);
        check({data_out_i, data_out_q} == 2'b10, "post_rst_phase0_data",
              int'({data_out_i, data_out_q}), 2);

        // reset with a leftover bit pending (3/4, after two inputs)
        do_reset();
        drive(3'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle();
        drive(3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle();
        rst = 1'b1;
        drive(3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle();
        rst = 1'b0;
        drive(3'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle();
        check(data_out_req == 1'b1, "leftover_drop_req", int'(data_out_req), 1);
        check({data_out_i, data_out_q} == 2'b11, "leftover_drop_data",
              int'({data_out_i, data_out_q}), 3);
        check(rate_active == 3'd2, "leftover_drop_rate", int'(rate_active), 2);

        // randomized traffic against the model
        do_reset();
        mon_en = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            logic [2:0] r;
            r = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : rate;
            drive(r, 1'($urandom), 1'($urandom), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 7);
            cycle();
        end
        drive(rate, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 4; n++) cycle();
        check(expq.size() == 0, "random_drain", expq.size(), 0);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
